// File: rtl/uart_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader_pkg
// Purpose  : Shared state encoding and constants for the UART boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } boot_state_t;

  localparam logic [7:0] BOOT_MAGIC           = 8'hA5;
  localparam int         BOOT_DEFAULT_TIMEOUT = 1_000_000;

endpackage
`default_nettype wire

// File: rtl/uart_boot_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module   : boot_timeout
// Purpose  : Inter-byte watchdog; down-counter reloaded by clr_i, expires at 0.
// Revision : 1.0 - initial release
// ============================================================================
module boot_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= CNT_W'(TIMEOUT_CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : Parses MAGIC/LEN/payload frames from the UART, writes LE words to
//            imem with the core held in reset, then releases the core.
//            Optional trailing XOR checksum byte: UART_BOOT_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int         ADDR_W         = 10,
  parameter int         BASE_ADDR      = 0,
  parameter int         TIMEOUT_CYCLES = BOOT_DEFAULT_TIMEOUT,
  parameter logic [7:0] MAGIC          = BOOT_MAGIC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  boot_state_t       state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, done_q, err_q;
`ifdef UART_BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        w_tmo_clr, w_tmo_en, w_tmo_expired;
  logic [15:0] w_len_full;
  logic        w_last_word;

  assign w_len_full  = {rx_data, len_q[7:0]};
  assign w_last_word = (({1'b0, word_idx_q} + 17'd1) == {1'b0, len_q});

  boot_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_tmo_clr),
    .en_i     (w_tmo_en),
    .expired_o(w_tmo_expired)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    w_tmo_clr  = 1'b1;
    w_tmo_en   = 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      IDLE, ERROR: begin
        if (rx_valid && (rx_data == MAGIC)) begin
          state_d = LEN_LO;
`ifdef UART_BOOT_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end

      LEN_LO: begin
        w_tmo_clr = rx_valid;
        w_tmo_en  = 1'b1;
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = LEN_HI;
        end else if (w_tmo_expired) begin
          state_d = ERROR;
        end
      end

      LEN_HI: begin
        w_tmo_clr = rx_valid;
        w_tmo_en  = 1'b1;
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          if ({1'b0, w_len_full} > MAX_LEN) begin
            state_d = ERROR;
          end else if (w_len_full == 16'd0) begin
`ifdef UART_BOOT_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            word_idx_d = 16'd0;
            byte_idx_d = 2'd0;
            state_d    = DATA;
          end
        end else if (w_tmo_expired) begin
          state_d = ERROR;
        end
      end

      DATA: begin
        w_tmo_clr = rx_valid;
        w_tmo_en  = 1'b1;
        if (rx_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(BASE_ADDR) + word_idx_q[ADDR_W-1:0];
            wdata_d = word_d;
            state_d = WRITE;
          end
        end else if (w_tmo_expired) begin
          state_d = ERROR;
        end
      end

      // Timer holds here; a byte landing in this cycle starts the next word.
      WRITE: begin
        w_tmo_clr  = rx_valid;
        word_idx_d = word_idx_q + 16'd1;
        if (w_last_word) begin
`ifdef UART_BOOT_CHECKSUM_EN
          state_d = CSUM;
          if (rx_valid) begin
            state_d = (rx_data == csum_q) ? DONE : ERROR;
          end
`else
          state_d = DONE;
`endif
        end else begin
          state_d    = DATA;
          byte_idx_d = 2'd0;
          if (rx_valid) begin
            word_d[7:0] = rx_data;
            byte_idx_d  = 2'd1;
`ifdef UART_BOOT_CHECKSUM_EN
            csum_d      = csum_q ^ rx_data;
`endif
          end
        end
      end

`ifdef UART_BOOT_CHECKSUM_EN
      CSUM: begin
        w_tmo_clr = rx_valid;
        w_tmo_en  = 1'b1;
        if (rx_valid) begin
          state_d = (rx_data == csum_q) ? DONE : ERROR;
        end else if (w_tmo_expired) begin
          state_d = ERROR;
        end
      end
`endif

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hold_q     <= (state_d != DONE);
      done_q     <= (state_d == DONE);
      err_q      <= (state_d == ERROR);
`ifdef UART_BOOT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_rst_hold = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Controller that sequences the UART receiver at boot.
- Parses a framed byte stream (magic, length, payload) and assembles little-endian 32-bit words.
- Writes the words into instruction memory while the CPU core is held in reset.
- Releases the core after a successful load. Sits between the uart receiver outputs and the imem write port / core reset.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- BASE_ADDR, 0, first word address written.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes inside a frame.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  byte from the uart receiver.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- imem_we  out  1  imem write enable, one-cycle pulse.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- cpu_rst_hold  out  1  holds the core in reset while high.
- load_done  out  1  sticky: load completed.
- load_err  out  1  sticky: frame error.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE. Outputs: imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_hold=1, load_done=0, load_err=0. Internal counters cleared. A reset mid-frame abandons the frame; no further writes occur.
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN words of 4 bytes each (byte0 = bits 7:0).
- Each cycle with rx_valid=1 consumes exactly one byte. Bytes are ignored when rx_valid=0.
- States and transitions:
  - IDLE: on byte==MAGIC -> LEN_LO. Other bytes are discarded.
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8].
    - If len > 2**ADDR_W -> ERROR.
    - If len==0 -> DONE.
    - Otherwise word_idx=0, byte_idx=0 -> DATA.
  - DATA: shift byte into word[8*byte_idx +: 8]; byte_idx++. On byte_idx==3 -> WRITE.
  - WRITE (exactly 1 cycle): imem_we=1, imem_addr=BASE_ADDR+word_idx (truncated to ADDR_W, wraps modulo 2**ADDR_W), imem_wdata=word.
    - word_idx++.
    - If word_idx+1==len -> DONE, else -> DATA.
    - A byte arriving during WRITE is captured as the next byte_idx 0; it is not dropped.
  - DONE: cpu_rst_hold=0, load_done=1. All bytes are ignored until rst.
  - ERROR: load_err=1, cpu_rst_hold=1. A MAGIC byte clears load_err and -> LEN_LO.
- Latency: imem_we is asserted the cycle after the rx_valid of the 4th byte of a word.
  - cpu_rst_hold falls the cycle after the last WRITE.
  - If len==0, cpu_rst_hold falls the cycle after LEN_HI.
- Timeout: the counter resets on every rx_valid and increments in LEN_LO, LEN_HI and DATA. On reaching TIMEOUT_CYCLES -> ERROR. The counter is inactive in IDLE, DONE and ERROR.
- Outputs are registered. imem_addr and imem_wdata hold their last values when imem_we=0.

Optional Feature:
- Macro: UART_BOOT_CHECKSUM_EN.
- With the macro defined:
  - A CSUM state follows the last WRITE, or LEN_HI when len==0.
  - The expected byte equals the XOR of all payload bytes.
  - Match -> DONE. Mismatch -> ERROR. Timeout applies in CSUM.
- Without the macro: CSUM is absent and transitions go directly to DONE as above.

Decomposition:
- Package common:
  - boot_state_t enum {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, DONE, ERROR}.
  - BOOT_MAGIC constant.
  - BOOT_DEFAULT_TIMEOUT constant.
- One sub-module: boot_timeout.
  - Parameterised down-counter with clear/enable inputs and an expired output.
  - Instantiated once.
- Byte assembly and the FSM stay in uart_boot_loader.

Test Plan:
- Frame A5 02 00 78 56 34 12 EF BE AD DE -> imem writes (BASE+0, 32'h12345678) then (BASE+1, 32'hDEADBEEF); cpu_rst_hold falls 1 cycle after the 2nd write; load_done=1.
- Bytes 00 FF then A5 00 00 -> first two bytes ignored; DONE with no writes; cpu_rst_hold=0.
- A5 01 00 11 22, then no byte for TIMEOUT_CYCLES (set to 50) -> load_err=1, no write, cpu_rst_hold=1. A new A5 01 00 44 33 22 11 -> write 32'h11223344, load_done=1.
- Length 0x0401 with ADDR_W=10 -> ERROR immediately after LEN_HI.
- rst asserted after 2 payload bytes -> all outputs at reset values next cycle. A full frame afterwards loads correctly from word 0.
- With UART_BOOT_CHECKSUM_EN: A5 01 00 01 02 04 08 0F -> DONE. The same frame ending 0E -> ERROR, load_done=0.
